// File: rtl/cross_bar_pkg.sv
// Shared types and the round-robin pick helper for the crossbar connection scheduler.
package cross_bar_pkg;

  typedef enum logic {IDLE, ACTIVE} state_type;

  localparam int unsigned RR_MAX   = 64;
  localparam int unsigned RR_IDX_W = $clog2(RR_MAX);

  typedef struct packed {
    logic        found;
    int unsigned idx;
  } rr_pick_type;

  // Returns the first set bit of req scanning from ptr+1 upward, wrapping modulo n.
  function automatic rr_pick_type rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    rr_pick_type res;
    int unsigned c;
    res = '{found: 1'b0, idx: 0};
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        c = ptr + k;
        if (c >= n) c = c - n;
        if (!res.found && req[c[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = c;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cross_bar_rr_arbiter.sv
// One output port's connection FSM: round-robin grant in IDLE, hold until last beat in ACTIVE.
module cross_bar_rr_arbiter #(
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned CHANNEL_NO = 2**MSEL_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CHANNEL_NO-1:0] cand,
  input  logic                  port_enable,
  input  logic                  beat_last,
  output logic                  sel_valid,
  output logic [MSEL_WIDTH-1:0] sel_bin,
  output logic [CHANNEL_NO-1:0] sel_onehot
);
  import cross_bar_pkg::*;

  state_type             state;
  logic [MSEL_WIDTH-1:0] rr_ptr;
  rr_pick_type           pick;
  logic [MSEL_WIDTH-1:0] pick_bin;

  always_comb begin
    pick     = rr_pick(RR_MAX'(cand), 32'(rr_ptr), CHANNEL_NO);
    pick_bin = MSEL_WIDTH'(pick.idx);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      rr_ptr     <= MSEL_WIDTH'(CHANNEL_NO - 1);
      sel_valid  <= 1'b0;
      sel_bin    <= '0;
      sel_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (port_enable && pick.found) begin
            state      <= ACTIVE;
            rr_ptr     <= pick_bin;
            sel_valid  <= 1'b1;
            sel_bin    <= pick_bin;
            sel_onehot <= CHANNEL_NO'(1) << pick_bin;
          end
        end
        ACTIVE: begin
          // sel_bin deliberately keeps the last winner after release.
          if (beat_last) begin
            state      <= IDLE;
            sel_valid  <= 1'b0;
            sel_onehot <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/cross_bar_scheduler_mxn.sv
// Packet-granular MxN crossbar connection scheduler: per-output round-robin arbiters plus grant fan-in.
module cross_bar_scheduler_mxn #(
  parameter int unsigned MSEL_WIDTH = 2,
  parameter int unsigned CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int unsigned NSEL_WIDTH = 2,
  parameter int unsigned PORT_NO    = 2**NSEL_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CHANNEL_NO-1:0] s_req,
  input  logic [NSEL_WIDTH-1:0] s_req_dest [CHANNEL_NO],
  output logic [CHANNEL_NO-1:0] s_grant,
  input  logic [PORT_NO-1:0]    m_port_enable,
  input  logic [PORT_NO-1:0]    m_beat_last,
  output logic [PORT_NO-1:0]    m_sel_valid,
  output logic [MSEL_WIDTH-1:0] m_sel_bin [PORT_NO],
  output logic [CHANNEL_NO-1:0] m_sel_onehot [PORT_NO]
);
  import cross_bar_pkg::*;

  logic [CHANNEL_NO-1:0] cand [PORT_NO];

  // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
  always_comb begin
    s_grant = '0;
    for (int j = 0; j < int'(PORT_NO); j++) begin
      if (m_sel_valid[j]) s_grant[m_sel_bin[j]] = 1'b1;
    end
  end

  // Destinations outside 0..PORT_NO-1 match no arbiter and are thereby ignored.
  always_comb begin
    for (int j = 0; j < int'(PORT_NO); j++) begin
      for (int i = 0; i < int'(CHANNEL_NO); i++) begin
        cand[j][i] = s_req[i] && (s_req_dest[i] == NSEL_WIDTH'(j)) && !s_grant[i];
      end
    end
  end

  for (genvar j = 0; j < int'(PORT_NO); j++) begin : g_port
    cross_bar_rr_arbiter #(
      .MSEL_WIDTH (MSEL_WIDTH),
      .CHANNEL_NO (CHANNEL_NO)
    ) u_arb (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .cand        (cand[j]),
      .port_enable (m_port_enable[j]),
      .beat_last   (m_beat_last[j]),
      .sel_valid   (m_sel_valid[j]),
      .sel_bin     (m_sel_bin[j]),
      .sel_onehot  (m_sel_onehot[j])
    );
  end

endmodule
